// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: FIFO-buffered ALU issue stage with early/late adder hazard bubbles,
// sink credit gating and tag re-alignment with the ALU result strobe. Requires STAGE >= 3.
module alu_issue_ctrl #(
    parameter int D_WIDTH    = 64,
    parameter int STAGE      = 6,
    parameter int FIFO_DEPTH = 8,
    parameter int TAG_W      = 8,
    parameter int CREDITS    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         in_opcode,
    input  logic [D_WIDTH-1:0] in_op0,
    input  logic [D_WIDTH-1:0] in_op1,
    input  logic [D_WIDTH-1:0] in_opq,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               alu_valid_i,
    output logic [4:0]         alu_opcode,
    output logic [D_WIDTH-1:0] alu_in0,
    output logic [D_WIDTH-1:0] alu_in1,
    output logic [D_WIDTH-1:0] alu_inq,
    input  logic               alu_valid_o,
    output logic               res_valid,
    output logic [TAG_W-1:0]   res_tag,
    input  logic               cred_ret,
    output logic [15:0]        bubble_cnt,
    output logic               err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [3:0] M_ADD = 4'd1, M_SUB = 4'd2, M_MAC = 4'd4, M_MMAC = 4'd6, M_BFU = 4'd7, M_IBFU = 4'd8;

    typedef struct packed {
        logic [4:0]         opcode;
        logic [D_WIDTH-1:0] op0;
        logic [D_WIDTH-1:0] op1;
        logic [D_WIDTH-1:0] opq;
        logic [TAG_W-1:0]   tag;
    } req_t;

    req_t                     mem [FIFO_DEPTH];
    req_t                     head;
    logic [AW:0]              wp, rp;
    logic [CW-1:0]            cred;
    logic [STAGE-3:0]         hist;
    logic [STAGE-2:0]         lv;
    logic [STAGE-1:0][TAG_W:0] tp;
    logic [TAG_W-1:0]         alu_tag;
    logic full, empty, push, can_go, hazard, issue, consume, cred_ovf, cred_inc;

    function automatic logic is_late(input logic [3:0] m);
        return m == M_BFU || m == M_MAC || m == M_MMAC;
    endfunction

    function automatic logic is_early(input logic [3:0] m);
        return m == M_ADD || m == M_SUB || m == M_IBFU;
    endfunction

    // lv[k] = late() of the op presented k cycles before the current one
    always_comb begin
        head     = mem[rp[AW-1:0]];
        empty    = wp == rp;
        full     = (wp ^ rp) == {1'b1, {AW{1'b0}}};
        in_ready = !full;
        push     = in_valid && !full && !flush;
        lv       = {hist, is_late(alu_opcode[3:0])};
        hazard   = is_early(head.opcode[3:0]) && lv[STAGE-2];
        can_go   = !empty && cred != '0 && !flush;
        issue    = can_go && !hazard;
        consume  = issue && head.opcode[3:0] != 4'd0;
        cred_ovf = cred_ret && cred == CW'(CREDITS);
        cred_inc = cred_ret && !cred_ovf;
        res_valid = alu_valid_o;
        res_tag   = tp[STAGE-1][TAG_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp[AW-1:0]] <= '{in_opcode, in_op0, in_op1, in_opq, in_tag};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp          <= '0;
            rp          <= '0;
            cred        <= CW'(CREDITS);
            hist        <= '0;
            tp          <= '0;
            alu_valid_i <= 1'b0;
            alu_opcode  <= '0;
            alu_in0     <= '0;
            alu_in1     <= '0;
            alu_inq     <= '0;
            alu_tag     <= '0;
            bubble_cnt  <= '0;
            err         <= 1'b0;
        end else begin
            wp          <= wp + (AW+1)'(push);
            rp          <= flush ? wp : rp + (AW+1)'(issue);
            cred        <= cred - CW'(consume) + CW'(cred_inc);
            hist        <= lv[STAGE-3:0];
            tp          <= {tp[STAGE-2:0], {alu_valid_i, alu_tag}};
            alu_valid_i <= consume;
            alu_opcode  <= issue ? head.opcode : 5'd0;
            if (issue) begin
                alu_in0 <= head.op0;
                alu_in1 <= head.op1;
                alu_inq <= head.opq;
                alu_tag <= head.tag;
            end
            if (can_go && hazard && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
            err         <= err || cred_ovf || (alu_valid_o != tp[STAGE-1][TAG_W]);
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed checks of issue latency, hazard bubbles, credits, flush, err and reset.
module tb_alu_issue_ctrl;
    localparam int STAGE = 6;
    localparam logic [4:0] ADD = 5'd1, SUB = 5'd2, MUL = 5'd3, MAC = 5'd4, BFU = 5'd7, IBFU = 5'd8;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready;
    logic [4:0]  in_opcode, alu_opcode;
    logic [63:0] in_op0, in_op1, in_opq, alu_in0, alu_in1, alu_inq;
    logic [7:0]  in_tag, res_tag;
    logic        alu_valid_i, alu_valid_o, res_valid, cred_ret, err;
    logic [15:0] bubble_cnt;
    logic        auto_ret, man_ret, force_vo;
    logic [STAGE-1:0] vpipe;
    int          errors = 0, checks = 0, cyc = 0, res_cnt = 0;
    int          iss_cyc[$];
    logic [4:0]  iss_op[$];

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_op0(in_op0), .in_op1(in_op1), .in_opq(in_opq), .in_tag(in_tag),
        .alu_valid_i(alu_valid_i), .alu_opcode(alu_opcode), .alu_in0(alu_in0), .alu_in1(alu_in1),
        .alu_inq(alu_inq), .alu_valid_o(alu_valid_o), .res_valid(res_valid), .res_tag(res_tag),
        .cred_ret(cred_ret), .bubble_cnt(bubble_cnt), .err(err)
    );

    always #5 clk = ~clk;

    // ALU stand-in: fixed STAGE-cycle valid pipe; sink returns a credit the cycle after issue
    always @(posedge clk or negedge rst_n)
        if (!rst_n) vpipe <= '0;
        else vpipe <= {vpipe[STAGE-2:0], alu_valid_i};
    assign alu_valid_o = vpipe[STAGE-1] | force_vo;
    assign cred_ret    = (auto_ret & alu_valid_i) | man_ret;

    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (alu_valid_i) begin
            iss_cyc.push_back(cyc);
            iss_op.push_back(alu_opcode);
        end
        if (res_valid) res_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic push_op(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b, input logic [7:0] tag);
        in_valid = 1'b1; in_opcode = op; in_op0 = a; in_op1 = b; in_opq = a ^ b; in_tag = tag;
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 0; in_valid = 0; in_opcode = 0; in_op0 = 0; in_op1 = 0; in_opq = 0; in_tag = 0;
        auto_ret = 1; man_ret = 0; force_vo = 0;
        tick(2);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if ({alu_valid_i, alu_opcode, alu_in0} !== '0) begin errors++; $display("FAIL reset_alu: got %b/%0h/%0h want 0", alu_valid_i, alu_opcode, alu_in0); end
        checks++; if ({res_valid, res_tag, bubble_cnt, err} !== '0) begin errors++; $display("FAIL reset_misc: got %b/%0h/%0h/%b want 0", res_valid, res_tag, bubble_cnt, err); end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_single_add();
        push_op(ADD, 64'd3, 64'd4, 8'h11);
        checks++; if (alu_valid_i !== 1'b0) begin errors++; $display("FAIL add_early: got %b want 0", alu_valid_i); end
        tick(1);
        checks++; if ({alu_valid_i, alu_opcode} !== {1'b1, ADD} || alu_in0 !== 64'd3 || alu_in1 !== 64'd4)
            begin errors++; $display("FAIL add_issue: got %b/%0d/%0d/%0d want 1/1/3/4", alu_valid_i, alu_opcode, alu_in0, alu_in1); end
        tick(1);
        checks++; if (alu_valid_i !== 1'b0 || alu_opcode !== 5'd0 || alu_in0 !== 64'd3)
            begin errors++; $display("FAIL add_hold: got %b/%0d/%0d want 0/0/3", alu_valid_i, alu_opcode, alu_in0); end
        tick(STAGE - 2);
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL add_res_early: got %b want 0", res_valid); end
        tick(1);
        checks++; if (res_valid !== 1'b1 || res_tag !== 8'h11) begin errors++; $display("FAIL add_res: got %b/%0h want 1/11", res_valid, res_tag); end
        tick(10);
    endtask

    task automatic test_mac_hazard();
        int b = iss_cyc.size();
        logic [15:0] bc = bubble_cnt;
        push_op(MAC, 1, 2, 8'h20);
        for (int i = 0; i < 4; i++) push_op(MUL, i, i, 8'h21 + 8'(i));
        push_op(ADD, 5, 6, 8'h25);
        tick(15);
        checks++; if (iss_cyc.size() - b !== 6) begin errors++; $display("FAIL mac_count: got %0d want 6", iss_cyc.size() - b); end
        else begin
            checks++; if (iss_cyc[b+4] - iss_cyc[b] !== 4) begin errors++; $display("FAIL mac_mul_gap: got %0d want 4", iss_cyc[b+4] - iss_cyc[b]); end
            checks++; if (iss_cyc[b+5] - iss_cyc[b] !== 6 || iss_op[b+5] !== ADD)
                begin errors++; $display("FAIL mac_add_gap: got %0d/%0d want 6/1", iss_cyc[b+5] - iss_cyc[b], iss_op[b+5]); end
        end
        checks++; if (bubble_cnt !== bc + 16'd1) begin errors++; $display("FAIL mac_bubbles: got %0d want %0d", bubble_cnt, bc + 16'd1); end
    endtask

    task automatic test_bfu_hazard();
        int b = iss_cyc.size();
        logic [15:0] bc = bubble_cnt;
        push_op(BFU, 1, 1, 8'h30);
        push_op(IBFU, 2, 2, 8'h31);
        tick(12);
        checks++; if (iss_cyc.size() - b !== 2 || iss_cyc[b+1] - iss_cyc[b] !== 1 || bubble_cnt !== bc)
            begin errors++; $display("FAIL bfu_ibfu: got n=%0d bubbles=%0d want n=2 gap 1 bubbles=%0d", iss_cyc.size() - b, bubble_cnt, bc); end
        b = iss_cyc.size();
        push_op(BFU, 1, 1, 8'h32);
        for (int i = 0; i < 4; i++) push_op(MUL, i, i, 8'h33);
        push_op(SUB, 9, 4, 8'h34);
        tick(15);
        checks++; if (iss_cyc.size() - b !== 6 || iss_cyc[b+5] - iss_cyc[b] !== 6 || iss_op[b+5] !== SUB)
            begin errors++; $display("FAIL bfu_sub: got n=%0d want 6 with SUB 6 cycles after BFU", iss_cyc.size() - b); end
        checks++; if (bubble_cnt !== bc + 16'd1) begin errors++; $display("FAIL bfu_bubbles: got %0d want %0d", bubble_cnt, bc + 16'd1); end
    endtask

    task automatic test_credits();
        int b = iss_cyc.size();
        auto_ret = 0;
        for (int i = 0; i < 6; i++) push_op(ADD, i, 1, 8'h40 + 8'(i));
        tick(12);
        checks++; if (iss_cyc.size() - b !== 4) begin errors++; $display("FAIL cred_stall: got %0d issued want 4", iss_cyc.size() - b); end
        man_ret = 1;
        tick(1);
        man_ret = 0;
        checks++; if (alu_valid_i !== 1'b0) begin errors++; $display("FAIL cred_wait: got %b want 0", alu_valid_i); end
        tick(1);
        checks++; if (alu_valid_i !== 1'b1 || alu_opcode !== ADD) begin errors++; $display("FAIL cred_fifth: got %b/%0d want 1/1", alu_valid_i, alu_opcode); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL cred_err: got %b want 0", err); end
        tick(3);
    endtask

    task automatic test_flush();
        int b = iss_cyc.size();
        for (int i = 0; i < 6; i++) push_op(MUL, i, i, 8'h50);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fifo_seven: got in_ready %b want 1", in_ready); end
        push_op(MUL, 7, 7, 8'h57);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fifo_full: got in_ready %b want 0", in_ready); end
        flush = 1; in_valid = 1; in_opcode = MUL;
        tick(1);
        flush = 0; in_valid = 0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", in_ready); end
        for (int i = 0; i < 4; i++) begin
            man_ret = 1; tick(1); man_ret = 0; tick(1);
        end
        tick(4);
        checks++; if (iss_cyc.size() !== b) begin errors++; $display("FAIL flush_drop: got %0d issued want 0", iss_cyc.size() - b); end
    endtask

    task automatic test_err_and_reset();
        man_ret = 1; tick(1); man_ret = 0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_cred_ovf: got %b want 1", err); end
        do_reset();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b want 0", err); end
        force_vo = 1; tick(1); force_vo = 0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_misalign: got %b want 1", err); end
        do_reset();
        auto_ret = 1;
        push_op(MAC, 1, 2, 8'h60);
        for (int i = 0; i < 4; i++) push_op(MUL, i, i, 8'h61);
        push_op(ADD, 3, 3, 8'h62);
        tick(3);
        checks++; if (bubble_cnt !== 16'd1) begin errors++; $display("FAIL pre_reset_bubble: got %0d want 1", bubble_cnt); end
        rst_n = 1'b0;
        #1;
        checks++; if ({alu_valid_i, alu_opcode, alu_in0, bubble_cnt, err} !== '0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL async_reset: got %b/%0d/%0h/%0d/%b want all 0", alu_valid_i, alu_opcode, alu_in0, bubble_cnt, err); end
        tick(1);
        rst_n = 1'b1;
        begin
            int r = res_cnt;
            int b = iss_cyc.size();
            tick(12);
            checks++; if (res_cnt !== r || iss_cyc.size() !== b || err !== 1'b0)
                begin errors++; $display("FAIL post_reset_quiet: got res=%0d iss=%0d err=%b want 0/0/0", res_cnt - r, iss_cyc.size() - b, err); end
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_mac_hazard();
        test_bfu_hazard();
        test_credits();
        test_flush();
        test_err_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
